// File: rtl/systolic_tile_writeback.sv
// systolic_tile_writeback
// Captures a finished 8x8 result tile with its destination geometry and
// writes it out one row per memory transaction, masking the lanes beyond the
// valid column count and honouring write_ready backpressure. Capturing the
// tile up front frees the array driver to start the next multiply while the
// writeback is still draining.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start; all write outputs are 0
// S_WRITE | presenting row row_q until the memory accepts it
// S_DONE  | one-cycle completion pulse, then back to S_IDLE

module systolic_tile_writeback #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int BANDWIDTH  = 8,
    parameter int DIM_WIDTH  = 8
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic [7:0][7:0][DATA_WIDTH-1:0]       tile_in,
    input  logic [ADDR_WIDTH-1:0]                 base_C,
    input  logic [DIM_WIDTH-1:0]                  dim_col_C,
    input  logic [DIM_WIDTH-1:0]                  dim_row_C,
    output logic                                  write,
    output logic [ADDR_WIDTH-1:0]                 write_addr,
    output logic [BANDWIDTH-1:0][DATA_WIDTH-1:0]  writedata,
    output logic [BANDWIDTH-1:0]                  write_mask,
    input  logic                                  write_ready,
    output logic                                  busy,
    output logic                                  done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                              state;
    logic [7:0][7:0][DATA_WIDTH-1:0]     tile_q;
    logic [2:0]                          row_q;
    logic [3:0]                          nrows_q;
    logic [DIM_WIDTH-1:0]                stride_q;

    logic [3:0]                          cap_ncols;
    logic [3:0]                          cap_nrows;
    logic [BANDWIDTH-1:0]                cap_mask;
    logic [BANDWIDTH-1:0][DATA_WIDTH-1:0] cap_row;
    logic [BANDWIDTH-1:0][DATA_WIDTH-1:0] next_row;
    logic [2:0]                          row_next;
    logic [ADDR_WIDTH-1:0]               stride_ext;
    logic                                last_row;

    // Clamp the incoming geometry and pre-build the masked rows that get
    // loaded into writedata on capture and on each accepted row.
    always_comb begin
        cap_ncols  = (dim_col_C > DIM_WIDTH'(8)) ? 4'd8 : dim_col_C[3:0];
        cap_nrows  = (dim_row_C > DIM_WIDTH'(8)) ? 4'd8 : dim_row_C[3:0];
        row_next   = row_q + 3'd1;
        stride_ext = ADDR_WIDTH'(stride_q);
        last_row   = ({1'b0, row_q} == (nrows_q - 4'd1));
        cap_mask   = '0;
        cap_row    = '0;
        next_row   = '0;
        for (int c = 0; c < BANDWIDTH; c++) begin
            cap_mask[c] = (4'(c) < cap_ncols);
            cap_row[c]  = cap_mask[c]   ? tile_in[0][c]       : '0;
            // write_mask still holds the captured column mask while writing
            next_row[c] = write_mask[c] ? tile_q[row_next][c] : '0;
        end
    end

    // Sequencer: capture, row-by-row write with backpressure, done pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            tile_q     <= '0;
            row_q      <= '0;
            nrows_q    <= '0;
            stride_q   <= '0;
            write      <= 1'b0;
            write_addr <= '0;
            writedata  <= '0;
            write_mask <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        tile_q   <= tile_in;
                        stride_q <= dim_col_C;
                        nrows_q  <= cap_nrows;
                        row_q    <= '0;
                        busy     <= 1'b1;
                        if (cap_nrows == 4'd0 || cap_ncols == 4'd0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state      <= S_WRITE;
                            write      <= 1'b1;
                            write_addr <= base_C;
                            write_mask <= cap_mask;
                            writedata  <= cap_row;
                        end
                    end
                end
                S_WRITE: begin
                    if (write_ready) begin
                        if (last_row) begin
                            state      <= S_DONE;
                            write      <= 1'b0;
                            write_addr <= '0;
                            writedata  <= '0;
                            write_mask <= '0;
                            done       <= 1'b1;
                        end else begin
                            row_q      <= row_next;
                            write_addr <= write_addr + stride_ext;
                            writedata  <= next_row;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state      <= S_IDLE;
                    write      <= 1'b0;
                    write_addr <= '0;
                    writedata  <= '0;
                    write_mask <= '0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_tile_writeback.sv
// Testbench for systolic_tile_writeback: a transaction-level model predicts
// every row write and the done pulse; directed scenarios add literal checks.

module tb_systolic_tile_writeback;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int BW = 8;
    localparam int DMW = 8;

    logic                     clock = 1'b0;
    logic                     reset;
    logic                     start;
    logic [7:0][7:0][DW-1:0]  tile_in;
    logic [AW-1:0]            base_C;
    logic [DMW-1:0]           dim_col_C;
    logic [DMW-1:0]           dim_row_C;
    logic                     write;
    logic [AW-1:0]            write_addr;
    logic [BW-1:0][DW-1:0]    writedata;
    logic [BW-1:0]            write_mask;
    logic                     write_ready;
    logic                     busy;
    logic                     done;

    systolic_tile_writeback #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BANDWIDTH(BW), .DIM_WIDTH(DMW)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .tile_in(tile_in),
        .base_C(base_C), .dim_col_C(dim_col_C), .dim_row_C(dim_row_C),
        .write(write), .write_addr(write_addr), .writedata(writedata),
        .write_mask(write_mask), .write_ready(write_ready), .busy(busy),
        .done(done)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int edges  = 0;

    typedef struct {
        logic [AW-1:0]         addr;
        logic [BW-1:0][DW-1:0] data;
        logic [BW-1:0]         mask;
    } wr_t;

    // model state
    wr_t exp_q[$];
    bit  done_now = 1'b0;
    bit  next_done;
    bit  exp_write, exp_busy;
    int  nr, nc;
    wr_t w;

    // observation logs for the literal checks
    logic [AW-1:0]         acc_addr[$];
    logic [BW-1:0][DW-1:0] acc_data[$];
    logic [BW-1:0]         acc_mask[$];
    int                    done_cyc[$];
    int                    start_cyc;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(posedge clock) edges++;

    // compare DUT against the model every cycle, then advance the model
    always @(negedge clock) begin
        exp_write = (exp_q.size() > 0);
        exp_busy  = exp_write || done_now;
        chk("write", write, exp_write);
        chk("busy", busy, exp_busy);
        chk("done", done, done_now);
        if (exp_write) begin
            chk("write_addr", write_addr, exp_q[0].addr);
            chk("writedata", writedata, exp_q[0].data);
            chk("write_mask", write_mask, exp_q[0].mask);
        end else begin
            chk("idle_addr", write_addr, 0);
            chk("idle_data", writedata, 0);
            chk("idle_mask", write_mask, 0);
        end
        if (write && write_ready) begin
            acc_addr.push_back(write_addr);
            acc_data.push_back(writedata);
            acc_mask.push_back(write_mask);
        end
        if (done) done_cyc.push_back(edges + 1);

        next_done = 1'b0;
        if (reset) begin
            exp_q.delete();
        end else if (exp_write && write_ready) begin
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) next_done = 1'b1;
        end else if (!exp_busy && start) begin
            start_cyc = edges + 1;
            nr = (int'(dim_row_C) > 8) ? 8 : int'(dim_row_C);
            nc = (int'(dim_col_C) > 8) ? 8 : int'(dim_col_C);
            if (nr == 0 || nc == 0) begin
                next_done = 1'b1;
            end else begin
                for (int r = 0; r < nr; r++) begin
                    w.addr = AW'(int'(base_C) + r * int'(dim_col_C));
                    w.mask = 8'((1 << nc) - 1);
                    for (int c = 0; c < 8; c++)
                        w.data[c] = (c < nc) ? tile_in[r][c] : '0;
                    exp_q.push_back(w);
                end
            end
        end
        done_now = next_done;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_tile(input logic [15:0] seed);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                tile_in[r][c] = {seed + 16'(r), 16'(c)};
    endtask

    task automatic clear_logs();
        acc_addr.delete();
        acc_data.delete();
        acc_mask.delete();
        done_cyc.delete();
    endtask

    // start at edge t; bit k of ready_lo drops write_ready in cycle t+k
    task automatic run(input int base, input int dc, input int dr,
                       input logic [31:0] ready_lo, input int n_cyc);
        clear_logs();
        base_C    = AW'(base);
        dim_col_C = DMW'(dc);
        dim_row_C = DMW'(dr);
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= n_cyc; k++) begin
            write_ready = !ready_lo[k];
            tick();
        end
        write_ready = 1'b1;
    endtask

    logic [BW-1:0][DW-1:0] row_tmp;

    initial begin
        reset = 1'b1; start = 1'b0; write_ready = 1'b1;
        base_C = '0; dim_col_C = '0; dim_row_C = '0;
        set_tile(16'h0000);
        repeat (3) tick();
        reset = 1'b0;
        chk("reset_write", write, 0);
        chk("reset_done", done, 0);
        chk("reset_busy", busy, 0);
        tick();

        // full tile
        set_tile(16'hA000);
        run(140, 8, 8, 32'h0, 12);
        chk("full_ndone", done_cyc.size(), 1);
        chk("full_done_cyc", done_cyc[0] - start_cyc, 9);
        chk("full_nwrites", acc_addr.size(), 8);
        chk("full_addr0", acc_addr[0], 140);
        chk("full_addr7", acc_addr[7], 196);
        chk("full_mask", acc_mask[0], 8'hFF);
        row_tmp = acc_data[3];
        chk("full_r3c5", row_tmp[5], 32'hA003_0005);

        // backpressure: ready low in cycles t+1, t+2, t+5
        run(140, 8, 8, 32'h26, 16);
        chk("bp_done_cyc", done_cyc[0] - start_cyc, 12);
        chk("bp_nwrites", acc_addr.size(), 8);

        // partial tile
        set_tile(16'hB000);
        run(0, 3, 5, 32'h0, 10);
        chk("part_done_cyc", done_cyc[0] - start_cyc, 6);
        chk("part_addr4", acc_addr[4], 12);
        chk("part_mask", acc_mask[2], 8'h07);
        row_tmp = acc_data[2];
        chk("part_r2c2", row_tmp[2], 32'hB002_0002);
        chk("part_r2c4", row_tmp[4], 0);

        // zero dimensions
        run(50, 8, 0, 32'h0, 4);
        chk("zrow_done_cyc", done_cyc[0] - start_cyc, 1);
        chk("zrow_nwrites", acc_addr.size(), 0);
        run(50, 0, 3, 32'h0, 4);
        chk("zcol_done_cyc", done_cyc[0] - start_cyc, 1);
        chk("zcol_nwrites", acc_addr.size(), 0);

        // column count above 8 clamps lanes but keeps the full stride
        run(5, 10, 2, 32'h0, 6);
        chk("clamp_addr1", acc_addr[1], 15);
        chk("clamp_mask", acc_mask[1], 8'hFF);
        chk("clamp_done_cyc", done_cyc[0] - start_cyc, 3);

        // capture and ignore
        clear_logs();
        set_tile(16'hC000);
        base_C = 16'd40; dim_col_C = 8'd8; dim_row_C = 8'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        set_tile(16'hD000);
        base_C = 16'd999;
        for (int k = 1; k <= 10; k++) begin
            start = (k == 3);
            tick();
        end
        start = 1'b0;
        chk("ign_ndone", done_cyc.size(), 1);
        chk("ign_addr1", acc_addr[1], 48);
        row_tmp = acc_data[0];
        chk("ign_r0c0", row_tmp[0], 32'hC000_0000);

        // reset mid-tile
        clear_logs();
        set_tile(16'hE000);
        base_C = 16'd140; dim_col_C = 8'd8; dim_row_C = 8'd8;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_write", write, 0);
        chk("rst_busy", busy, 0);
        repeat (10) tick();
        chk("rst_ndone", done_cyc.size(), 0);

        // address wrap
        set_tile(16'hF000);
        run(65528, 8, 2, 32'h0, 5);
        chk("wrap_addr0", acc_addr[0], 16'hFFF8);
        chk("wrap_addr1", acc_addr[1], 0);

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/systolic_tile_writeback.md
# systolic_tile_writeback

Downstream stage of the systolic array driver. On `start` it captures the finished 8x8 result tile (`Out`) plus its destination geometry and writes it to memory one row per transaction, each row `BANDWIDTH` words wide, with per-lane masking for partial tiles and `write_ready` backpressure. Because the tile is captured on `start`, the driver can begin the next multiply while writeback is still in progress. It pulses `done` when the last row has been accepted.

## Interface
Parameters (macros from Macro.svh):
- `ADDR_WIDTH`, Macro.svh, word address width; addresses wrap modulo 2^ADDR_WIDTH.
- `DATA_WIDTH`, 32, width of one element (IEEE-754 single).
- `BANDWIDTH`, 8, words per memory transaction; equals the tile dimension.
- `DIM_WIDTH`, Macro.svh, width of dimension inputs.

Ports (one clock `clock`; reset is synchronous and active-high, named `reset`):
- `clock` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: capture request, sampled only in IDLE.
- `tile_in` in [7:0][7:0][DATA_WIDTH]: result tile; `tile_in[r][c]` is row r, column c.
- `base_C` in ADDR_WIDTH: address of element (0,0).
- `dim_col_C` in DIM_WIDTH: row stride in words, also the valid column count (clamped to 8).
- `dim_row_C` in DIM_WIDTH: valid row count (clamped to 8).
- `write` out 1: write request.
- `write_addr` out ADDR_WIDTH: address of lane 0 of the current row.
- `writedata` out [BANDWIDTH-1:0][DATA_WIDTH-1:0]: lane c = `tile[r][c]`.
- `write_mask` out BANDWIDTH: bit c set means lane c is written.
- `write_ready` in 1: memory accepts when `write && write_ready`.
- `busy` out 1: high in WRITE and DONE.
- `done` out 1: one-cycle completion pulse.

## Operation
- The FSM has three states: IDLE, WRITE, DONE.
- **IDLE**
  - On `start`, register `tile_in`, `base_C`, and the clamped values `ncols = min(dim_col_C, 8)`, `nrows = min(dim_row_C, 8)`, and `stride = dim_col_C`.
  - Set row counter r = 0 and address accumulator = `base_C`.
  - If `nrows == 0` or `ncols == 0`, go to DONE. Otherwise go to WRITE.
- **WRITE**
  - Drive `write = 1`, `write_addr` = accumulator, `writedata` = captured row r, and `write_mask[c] = (c < ncols)`.
  - Masked-off lanes are driven 0.
  - When `write_ready` is high:
    - accumulator += stride (adder only, no multiplier; wraps modulo 2^ADDR_WIDTH);
    - r += 1;
    - if r was `nrows - 1`, go to DONE.
  - While `write_ready` is low, all write outputs hold stable.
- **DONE**
  - Assert `done` for one cycle, then go to IDLE.
- `start` in WRITE or DONE is ignored. It is not queued.
- Inputs other than `write_ready` are don't-care after capture.
- Whenever `write = 0`: `write_addr`, `writedata`, and `write_mask` are 0.

## Timing
- Reset values:
  - state IDLE;
  - `write`, `busy`, `done` = 0;
  - `write_addr`, `writedata`, `write_mask` = 0;
  - the captured tile is cleared.
- All outputs are registered or decoded from registered state. There is no combinational path from inputs to outputs except that acceptance depends on `write_ready`.
- Latency, with `start` sampled at edge t:
  - `write` is high from cycle t+1.
  - With `write_ready` held high, row k is accepted at edge t+1+k.
  - `done` is high in cycle t+1+nrows. `busy` is high over cycles t+1 through t+1+nrows.
  - A new `start` is accepted at edge t+2+nrows at the earliest.
- Empty tile: `done` is high in cycle t+1 and no `write` is issued.
- Backpressure adds exactly one cycle per low `write_ready` cycle in WRITE.
- `reset` in any state returns to IDLE at the next edge. No further writes are issued and `done` does not fire.
- `reset` and `start` in the same cycle: `reset` wins.

## Test plan
- **Full tile:** base_C=140, dim_col_C=8, dim_row_C=8, write_ready=1, start at t.
  - Expect 8 writes at cycles t+1..t+8, addrs 140, 148, …, 196, mask 0xFF.
  - Lane c of row r equals `tile_in[r][c]` captured at t.
  - `done` in cycle t+9.
- **Backpressure:** same tile, write_ready low on cycles t+1, t+2 and t+5.
  - Each row is presented until accepted, outputs stable while stalled.
  - `done` in cycle t+12.
- **Partial tile:** dim_col_C=3, dim_row_C=5, base_C=0.
  - Expect addrs 0, 3, 6, 9, 12, mask 0x07, lanes 3–7 driven 0, `done` in cycle t+6.
- **Zero dimension:** dim_row_C=0 (and separately dim_col_C=0).
  - No `write`; `done` in cycle t+1.
- **Capture and ignore:**
  - Change `tile_in` and `base_C` after t; writes still use the values captured at t.
  - Pulse `start` at t+3; it is ignored and only one `done` fires.
- **Reset and wrap:**
  - `reset` at t+4 of a full tile: all outputs 0 from t+5 and no `done`.
  - Then base_C = 2^ADDR_WIDTH−8 with dim_col_C=8: row 1 address wraps to 0.
